// File: rtl/spi_mem_cache.sv
// Direct-mapped, one-word-per-line, write-through cache in front of a quad-SPI flash/PSRAM controller.
// Define SPI_MEM_CACHE_STATS_EN to add the hit_cnt/miss_cnt read statistics outputs.
module spi_mem_cache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [22:0] s_addr,
    input  logic        s_psram,
    input  logic [3:0]  s_wstrb,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [22:0] m_addr,
    output logic        m_psram,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
`ifdef SPI_MEM_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 24 - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, DONE} state_t;
    state_t state, state_d;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] line_vld;

    logic [22:0]      req_addr;
    logic             req_psram;
    logic [3:0]       req_wstrb;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             rd_vld;

    logic [IDX_W-1:0] s_idx, req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             lookup_hit;
    logic [31:0]      merged;

    assign s_idx      = s_addr[IDX_W-1:0];
    assign req_idx    = req_addr[IDX_W-1:0];
    assign req_tag    = {req_psram, req_addr[22:IDX_W]};
    assign lookup_hit = rd_vld && (rd_tag == req_tag);

    always_comb begin
        for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = req_wstrb[b] ? req_wdata[8*b +: 8] : rd_data[8*b +: 8];
    end

    logic accept, hit_rd, miss_rd, issue, fill_done, wr_done;

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        hit_rd    = 1'b0;
        miss_rd   = 1'b0;
        issue     = 1'b0;
        fill_done = 1'b0;
        wr_done   = 1'b0;
        case (state)
            IDLE: if (s_valid) begin
                accept  = 1'b1;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                if (req_wstrb != 4'd0) begin
                    issue   = 1'b1;
                    state_d = WRITE;
                end else if (lookup_hit) begin
                    hit_rd  = 1'b1;
                    state_d = DONE;
                end else begin
                    miss_rd = 1'b1;
                    issue   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: if (m_ready) begin
                fill_done = 1'b1;
                state_d   = DONE;
            end
            WRITE: if (m_ready) begin
                wr_done = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            s_rdata  <= 32'd0;
            m_valid  <= 1'b0;
            m_addr   <= 23'd0;
            m_psram  <= 1'b0;
            m_wstrb  <= 4'd0;
            m_wdata  <= 32'd0;
            line_vld <= '0;
            rd_vld   <= 1'b0;
        end else begin
            state   <= state_d;
            s_ready <= hit_rd | fill_done | wr_done;
            if (accept)    rd_vld  <= line_vld[s_idx];
            if (hit_rd)    s_rdata <= rd_data;
            if (fill_done) s_rdata <= m_rdata;
            if (issue) begin
                m_valid <= 1'b1;
                m_addr  <= req_addr;
                m_psram <= req_psram;
                m_wstrb <= req_wstrb;
                m_wdata <= req_wdata;
            end
            if (fill_done || wr_done) begin
                m_valid <= 1'b0;
                m_wstrb <= 4'd0;
            end
            if (fill_done) line_vld[req_idx] <= 1'b1;
        end
    end

    // Arrays carry no reset; array writes are gated by resetn so an abandoned transfer leaves no trace.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= s_addr;
            req_psram <= s_psram;
            req_wstrb <= s_wstrb;
            req_wdata <= s_wdata;
            rd_tag    <= tag_mem[s_idx];
            rd_data   <= data_mem[s_idx];
        end
        if (resetn && fill_done) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= m_rdata;
        end
        if (resetn && wr_done && lookup_hit)
            data_mem[req_idx] <= merged;
    end

`ifdef SPI_MEM_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit_rd)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_rd) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_mem_cache.sv
// Directed bench for spi_mem_cache: hits, misses, tag separation, write merge, conflicts, reset abort.
module tb_spi_mem_cache;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [22:0] s_addr = '0;
    logic        s_psram = 1'b0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] s_wdata = '0;
    logic [31:0] s_rdata;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [22:0] m_addr;
    logic        m_psram;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
`ifdef SPI_MEM_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    spi_mem_cache #(.LINES(64)) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_psram(s_psram),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_psram(m_psram),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef SPI_MEM_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream responder: answers after resp_delay cycles of m_valid, with resp_data.
    logic        resp_en = 1'b1;
    int          resp_delay = 0;
    logic [31:0] resp_data = '0;
    int          wait_cnt = 0;
    always @(negedge clk) begin
        if (m_ready) m_ready = 1'b0;
        else if (m_valid && resp_en) begin
            if (wait_cnt >= resp_delay) begin
                m_ready  = 1'b1;
                m_rdata  = resp_data;
                wait_cnt = 0;
            end else wait_cnt++;
        end
    end

    int          hs_cnt = 0;
    int          sr_cnt = 0;
    logic        sr_prev = 1'b0;
    int          sr_double = 0;
    logic [3:0]  last_wstrb;
    logic [31:0] last_wdata;
    logic [22:0] last_addr;
    logic        last_psram;
    always @(posedge clk) begin
        if (resetn && m_valid && m_ready) begin
            hs_cnt++;
            last_wstrb = m_wstrb;
            last_wdata = m_wdata;
            last_addr  = m_addr;
            last_psram = m_psram;
        end
        if (s_ready) sr_cnt++;
        if (s_ready && sr_prev) sr_double++;
        sr_prev = s_ready;
    end

    task automatic req(input logic psram, input logic [22:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input logic [31:0] resp,
                       output logic [31:0] rdata, output int lat);
        @(negedge clk);
        resp_data = resp;
        s_valid = 1'b1; s_psram = psram; s_addr = addr; s_wstrb = wstrb; s_wdata = wdata;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!s_ready && lat < 50);
        if (!s_ready) chk("req_timeout", 64'd1, 64'd0);
        rdata = s_rdata;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    logic [31:0] rd;
    int lat, hs0, sr0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_wstrb", m_wstrb, 0);
        chk("rst_s_rdata", s_rdata, 0);
        @(negedge clk); resetn = 1'b1;

        // cold read then re-read hit
        hs0 = hs_cnt; req(0, 23'h10, 4'h0, 0, 32'hDEADBEEF, rd, lat);
        chk("fill_rdata", rd, 32'hDEADBEEF);
        chk("fill_hs", hs_cnt - hs0, 1);
        chk("fill_wstrb", last_wstrb, 0);
        chk("fill_lat", lat, 3);
        hs0 = hs_cnt; req(0, 23'h10, 4'h0, 0, 32'h0, rd, lat);
        chk("hit_rdata", rd, 32'hDEADBEEF);
        chk("hit_hs", hs_cnt - hs0, 0);
        chk("hit_lat", lat, 2);
        repeat (3) @(posedge clk);
        #1 chk("rdata_hold", s_rdata, 32'hDEADBEEF);

        // PSRAM alias must miss and install its own tag
        hs0 = hs_cnt; req(1, 23'h10, 4'h0, 0, 32'hCAFEF00D, rd, lat);
        chk("psram_hs", hs_cnt - hs0, 1);
        chk("psram_sel", last_psram, 1);
        chk("psram_rdata", rd, 32'hCAFEF00D);
        hs0 = hs_cnt; req(1, 23'h10, 4'h0, 0, 32'h0, rd, lat);
        chk("psram_hit_hs", hs_cnt - hs0, 0);
        chk("psram_hit_rdata", rd, 32'hCAFEF00D);
        hs0 = hs_cnt; req(0, 23'h10, 4'h0, 0, 32'hDEADBEEF, rd, lat);
        chk("flash_evicted_hs", hs_cnt - hs0, 1);

        // write-through byte merge on a hit
        req(0, 23'h3, 4'h0, 0, 32'h11223344, rd, lat);
        hs0 = hs_cnt; req(0, 23'h3, 4'b0010, 32'h0000AA00, 32'h0, rd, lat);
        chk("wr_hs", hs_cnt - hs0, 1);
        chk("wr_wstrb", last_wstrb, 4'b0010);
        chk("wr_wdata", last_wdata, 32'h0000AA00);
        chk("wr_addr", last_addr, 23'h3);
        hs0 = hs_cnt; req(0, 23'h3, 4'h0, 0, 32'h0, rd, lat);
        chk("merge_hs", hs_cnt - hs0, 0);
        chk("merge_rdata", rd, 32'h1122AA44);

        // no allocate on write miss
        hs0 = hs_cnt; req(0, 23'h20, 4'hF, 32'h01020304, 32'h0, rd, lat);
        chk("wmiss_hs", hs_cnt - hs0, 1);
        hs0 = hs_cnt; req(0, 23'h20, 4'h0, 0, 32'h55667788, rd, lat);
        chk("noalloc_hs", hs_cnt - hs0, 1);
        chk("noalloc_rdata", rd, 32'h55667788);

        // conflict: 0x05 and 0x45 share index 5
        req(0, 23'h05, 4'h0, 0, 32'hA5A5A5A5, rd, lat);
        hs0 = hs_cnt; req(0, 23'h45, 4'h0, 0, 32'h5A5A5A5A, rd, lat);
        chk("conf_hs", hs_cnt - hs0, 1);
        chk("conf_rdata", rd, 32'h5A5A5A5A);
        hs0 = hs_cnt; req(0, 23'h05, 4'h0, 0, 32'h0A0A0A0A, rd, lat);
        chk("conf_re_hs", hs_cnt - hs0, 1);
        chk("conf_re_rdata", rd, 32'h0A0A0A0A);

`ifdef SPI_MEM_CACHE_STATS_EN
        chk("stat_hits", hit_cnt, 3);
        chk("stat_misses", miss_cnt, 8);
`endif

        // reset in the middle of a fill
        resp_en = 1'b0;
        @(negedge clk);
        s_valid = 1'b1; s_psram = 1'b0; s_addr = 23'h30; s_wstrb = 4'h0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!m_valid && lat < 20);
        chk("abort_mvalid_seen", m_valid, 1);
        sr0 = sr_cnt;
        @(negedge clk); resetn = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_mvalid", m_valid, 0);
        chk("abort_sready", s_ready, 0);
`ifdef SPI_MEM_CACHE_STATS_EN
        chk("abort_hit_cnt", hit_cnt, 0);
        chk("abort_miss_cnt", miss_cnt, 0);
`endif
        @(negedge clk); resetn = 1'b1; resp_en = 1'b1; wait_cnt = 0;
        repeat (2) @(posedge clk);
        #1 chk("abort_no_sready", sr_cnt - sr0, 0);
        hs0 = hs_cnt; req(0, 23'h30, 4'h0, 0, 32'h12345678, rd, lat);
        chk("abort_miss_hs", hs_cnt - hs0, 1);
        chk("abort_miss_rdata", rd, 32'h12345678);
        hs0 = hs_cnt; req(0, 23'h10, 4'h0, 0, 32'hDEADBEEF, rd, lat);
        chk("rst_clears_valid", hs_cnt - hs0, 1);

        chk("sready_single_pulse", sr_double, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
